spike_rate_decoder: RTL
=======================

SPIKE_RATE_DECODER -- requirements
Module: spike_rate_decoder

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of spike count and window length.
REQ-002 SHALL have parameter: ST_W, 7, width of the neuron membrane-state field.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: spike_in  input  1  spike bit from the upstream neuron (its output bit 7).
REQ-006 SHALL have port: state_in  input  ST_W  membrane state from the upstream neuron (its output bits 6:0).
REQ-007 SHALL have port: en  input  1  decoder enable.
REQ-008 SHALL have port: win_len  input  CNT_W  window length in cycles.
REQ-009 SHALL have port: rate_out  output  CNT_W  spikes counted in the last completed window.
REQ-010 SHALL have port: peak_out  output  ST_W  maximum state_in seen in the last completed window.
REQ-011 SHALL have port: out_valid  output  1  result available.
REQ-012 SHALL have port: out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port: overrun  output  1  sticky flag: a spike was dropped while a result was held.

Function
REQ-014 SHALL implement FSM states IDLE, COUNT, HOLD.
REQ-015 IDLE: en=1 -> COUNT next cycle, with spike count, cycle count and peak cleared and win_len latched; en=0 -> stay in IDLE.
REQ-016 Effective window length L SHALL be the latched win_len, with a latched value of 0 treated as L=1; win_len changes during a window SHALL be ignored.
REQ-017 COUNT: each cycle SHALL sample spike_in (count += 1 if high) and state_in (peak = max(peak, state_in), unsigned).
REQ-018 Spike count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-019 COUNT SHALL last exactly L cycles; the sample in the L-th cycle SHALL be included; next state is HOLD.
REQ-020 On entering HOLD, rate_out and peak_out SHALL load the final count and peak, and out_valid SHALL be 1 in the same cycle they become visible.
REQ-021 HOLD: rate_out, peak_out and out_valid=1 SHALL remain stable until the cycle in which out_ready=1 (handshake).
REQ-022 On handshake: en=1 -> COUNT next cycle with cleared counters (new window; latency from handshake to first sample is 1 cycle); en=0 -> IDLE; out_valid SHALL drop to 0 the next cycle.
REQ-023 spike_in=1 during any HOLD cycle, including the handshake cycle, SHALL NOT be counted and SHALL set overrun=1.
REQ-024 overrun SHALL remain 1 until reset.
REQ-025 en=0 during COUNT SHALL abort the window: next state IDLE, partial results discarded, rate_out/peak_out unchanged, out_valid stays 0.
REQ-026 en SHALL be ignored in HOLD except for choosing the post-handshake state.
REQ-027 out_ready SHALL be ignored when out_valid=0.
REQ-028 rate_out and peak_out SHALL hold their last values in IDLE and COUNT.

Reset
REQ-029 rst_n=0 at a clock edge SHALL force IDLE and clear rate_out, peak_out, out_valid, overrun and all internal counters to 0.
REQ-030 Reset asserted mid-COUNT or mid-HOLD SHALL discard the window with no handshake; out_valid=0 from the cycle after the reset edge.
REQ-031 Outputs SHALL NOT change asynchronously on rst_n.

Verification
REQ-032 win_len=10, en=1, spike_in high on window cycles 1,4,10 -> out_valid=1 after 10 COUNT cycles, rate_out=3.
REQ-033 win_len=4, state_in sequence 5,60,12,60 -> peak_out=60; win_len=0 with spike in the single window cycle -> rate_out=1.
REQ-034 win_len=255, spike_in held high, out_ready=1 -> rate_out=255, then the next window starts 1 cycle after the handshake.
REQ-035 out_ready held 0 for 5 cycles in HOLD with spike_in=1 -> rate_out and out_valid stable, overrun=1, overrun still 1 after the next window.
REQ-036 en dropped on window cycle 3 of 8 -> IDLE, out_valid never asserts, previous rate_out retained.
REQ-037 rst_n=0 for 1 cycle mid-HOLD -> out_valid=0, rate_out=0, overrun=0, state IDLE.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// rtl/spike_rate_decoder.sv - windowed spike-rate and peak-state decoder with held result handshake
module spike_rate_decoder #(
  parameter int CNT_W = 8,
  parameter int ST_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             spike_in,
  input  logic [ST_W-1:0]  state_in,
  input  logic             en,
  input  logic [CNT_W-1:0] win_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [ST_W-1:0]  peak_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ST_W-1:0]  pk_q, pk_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic [ST_W-1:0]  peak_q, peak_d;
  logic             ovr_q, ovr_d;

  logic [CNT_W-1:0] eff_len;
  logic [CNT_W-1:0] cnt_inc;
  logic [ST_W-1:0]  pk_max;
  logic             last_cycle;

  // A latched window length of zero still runs a single sample cycle.
  assign eff_len    = (win_len == '0) ? ONE : win_len;
  assign cnt_inc    = (spike_in && (cnt_q != CNT_MAX)) ? cnt_q + ONE : cnt_q;
  assign pk_max     = (state_in > pk_q) ? state_in : pk_q;
  assign last_cycle = (cyc_q == len_q - ONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = COUNT;
      COUNT: begin
        if (!en)             state_d = IDLE;
        else if (last_cycle) state_d = HOLD;
      end
      HOLD:    if (out_ready) state_d = en ? COUNT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state_q == HOLD);
    rate_out  = rate_q;
    peak_out  = peak_q;
    overrun   = ovr_q;
  end

  always_comb begin
    len_d  = len_q;
    cyc_d  = cyc_q;
    cnt_d  = cnt_q;
    pk_d   = pk_q;
    rate_d = rate_q;
    peak_d = peak_q;
    ovr_d  = ovr_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          len_d = eff_len;
          cyc_d = '0;
          cnt_d = '0;
          pk_d  = '0;
        end
      end
      COUNT: begin
        cnt_d = cnt_inc;
        pk_d  = pk_max;
        cyc_d = cyc_q + ONE;
        // The final sample is folded straight into the published result.
        if (en && last_cycle) begin
          rate_d = cnt_inc;
          peak_d = pk_max;
        end
      end
      HOLD: begin
        if (spike_in) ovr_d = 1'b1;
        if (out_ready && en) begin
          len_d = eff_len;
          cyc_d = '0;
          cnt_d = '0;
          pk_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q  <= '0;
      cyc_q  <= '0;
      cnt_q  <= '0;
      pk_q   <= '0;
      rate_q <= '0;
      peak_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      len_q  <= len_d;
      cyc_q  <= cyc_d;
      cnt_q  <= cnt_d;
      pk_q   <= pk_d;
      rate_q <= rate_d;
      peak_q <= peak_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule
